// File: rtl/buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// buzzer_sequencer
//   Shares the single piezo buzzer among three keypad-lock events: key click,
//   unlock success and wrong-code alarm. Each event plays a fixed square-wave
//   pattern. A higher-priority request preempts the current pattern
//   (ERR > OK > KEY). A request of the same priority restarts its own pattern.
//
// Ports
//   clk        in   system clock
//   RSTn       in   synchronous reset, ACTIVE-HIGH despite the name
//   req_key    in   key-click request pulse
//   req_ok     in   success request pulse
//   req_err    in   alarm request pulse
//   mute       in   level; forces buzzer low, sequencing keeps running
//   buzzer     out  registered square-wave drive
//   busy       out  a pattern is playing
//   active_id  out  0 none, 1 key, 2 ok, 3 err
//
// Build option
//   BUZZ_QUEUE_EN : when defined, a one-entry pending slot keeps a rejected
//                   lower-priority request and plays it as soon as the current
//                   pattern ends, with no idle cycle in between.
// -----------------------------------------------------------------------------
module buzzer_sequencer #(
   parameter int CNT_W      = 32,
   parameter int KEY_HALF   = 50000,
   parameter int KEY_LEN    = 10000000,
   parameter int OK_HALF    = 25000,
   parameter int OK_LEN     = 30000000,
   parameter int ERR_HALF   = 100000,
   parameter int ERR_GAP_LO = 5000000,
   parameter int ERR_GAP_HI = 10000000,
   parameter int ERR_LEN    = 15000000
) (
   input  logic       clk,
   input  logic       RSTn,
   input  logic       req_key,
   input  logic       req_ok,
   input  logic       req_err,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] active_id
);

   // State encoding equals both the reported id and the priority rank.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_KEY  = 2'd1,
      ST_OK   = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ZERO_C       = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C        = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] KEY_HALF_C   = CNT_W'(KEY_HALF);
   localparam logic [CNT_W-1:0] KEY_LEN_C    = CNT_W'(KEY_LEN);
   localparam logic [CNT_W-1:0] OK_HALF_C    = CNT_W'(OK_HALF);
   localparam logic [CNT_W-1:0] OK_LEN_C     = CNT_W'(OK_LEN);
   localparam logic [CNT_W-1:0] ERR_HALF_C   = CNT_W'(ERR_HALF);
   localparam logic [CNT_W-1:0] ERR_GAP_LO_C = CNT_W'(ERR_GAP_LO);
   localparam logic [CNT_W-1:0] ERR_GAP_HI_C = CNT_W'(ERR_GAP_HI);
   localparam logic [CNT_W-1:0] ERR_LEN_C    = CNT_W'(ERR_LEN);

   function automatic logic [CNT_W-1:0] half_of(input state_t s);
      case (s)
         ST_KEY:  half_of = KEY_HALF_C;
         ST_OK:   half_of = OK_HALF_C;
         ST_ERR:  half_of = ERR_HALF_C;
         default: half_of = ONE_C;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] len_of(input state_t s);
      case (s)
         ST_KEY:  len_of = KEY_LEN_C;
         ST_OK:   len_of = OK_LEN_C;
         ST_ERR:  len_of = ERR_LEN_C;
         default: len_of = ONE_C;
      endcase
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dur_q, dur_d;
   logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
   logic             tone_bit_q, tone_bit_d;
   logic             buzzer_q, buzzer_d;
   logic             busy_q, busy_d;
   logic [1:0]       active_id_q, active_id_d;
   state_t           win_s;
   logic             accept_s;
   logic             last_s;
   logic             gap_s;
`ifdef BUZZ_QUEUE_EN
   logic             pend_valid_q, pend_valid_d;
   state_t           pend_id_q, pend_id_d;
`endif

   // Pick the highest simultaneous request and decide whether it may take over.
   always_comb begin
      if (req_err) begin
         win_s = ST_ERR;
      end else if (req_ok) begin
         win_s = ST_OK;
      end else if (req_key) begin
         win_s = ST_KEY;
      end else begin
         win_s = ST_IDLE;
      end
      accept_s = (win_s != ST_IDLE) && (win_s >= state_q);
      last_s   = (state_q != ST_IDLE) && (dur_q == (len_of(state_q) - ONE_C));
   end

   // Next-state, duration and tone counters (plus the pending slot if built in).
   always_comb begin
      state_d    = state_q;
      dur_d      = dur_q;
      tone_cnt_d = tone_cnt_q;
      tone_bit_d = tone_bit_q;
`ifdef BUZZ_QUEUE_EN
      // A rejected request is merged first so one arriving on the last cycle
      // can already follow on without a gap.
      if ((win_s != ST_IDLE) && !accept_s &&
          (!pend_valid_q || (win_s >= pend_id_q))) begin
         pend_valid_d = 1'b1;
         pend_id_d    = win_s;
      end else begin
         pend_valid_d = pend_valid_q;
         pend_id_d    = pend_id_q;
      end
`endif
      if (accept_s) begin
         // New pattern always opens with the tone high.
         state_d    = win_s;
         dur_d      = ZERO_C;
         tone_cnt_d = ZERO_C;
         tone_bit_d = 1'b1;
      end else if (last_s) begin
`ifdef BUZZ_QUEUE_EN
         if (pend_valid_d) begin
            state_d      = pend_id_d;
            dur_d        = ZERO_C;
            tone_cnt_d   = ZERO_C;
            tone_bit_d   = 1'b1;
            pend_valid_d = 1'b0;
         end else begin
            state_d    = ST_IDLE;
            dur_d      = ZERO_C;
            tone_cnt_d = ZERO_C;
            tone_bit_d = 1'b0;
         end
`else
         state_d    = ST_IDLE;
         dur_d      = ZERO_C;
         tone_cnt_d = ZERO_C;
         tone_bit_d = 1'b0;
`endif
      end else if (state_q != ST_IDLE) begin
         dur_d = dur_q + ONE_C;
         if (tone_cnt_q == (half_of(state_q) - ONE_C)) begin
            tone_cnt_d = ZERO_C;
            tone_bit_d = ~tone_bit_q;
         end else begin
            tone_cnt_d = tone_cnt_q + ONE_C;
         end
      end else begin
         dur_d      = ZERO_C;
         tone_cnt_d = ZERO_C;
         tone_bit_d = 1'b0;
      end
   end

   // Output values derived from the next state so they line up with it.
   always_comb begin
      gap_s       = (state_d == ST_ERR) && (dur_d >= ERR_GAP_LO_C) && (dur_d < ERR_GAP_HI_C);
      buzzer_d    = tone_bit_d & (state_d != ST_IDLE) & ~gap_s & ~mute;
      busy_d      = (state_d != ST_IDLE);
      active_id_d = state_d;
   end

   // State and output registers; reset (active-high) overrides any request.
   always_ff @(posedge clk) begin
      if (RSTn) begin
         state_q      <= ST_IDLE;
         dur_q        <= ZERO_C;
         tone_cnt_q   <= ZERO_C;
         tone_bit_q   <= 1'b0;
         buzzer_q     <= 1'b0;
         busy_q       <= 1'b0;
         active_id_q  <= 2'd0;
`ifdef BUZZ_QUEUE_EN
         pend_valid_q <= 1'b0;
         pend_id_q    <= ST_IDLE;
`endif
      end else begin
         state_q      <= state_d;
         dur_q        <= dur_d;
         tone_cnt_q   <= tone_cnt_d;
         tone_bit_q   <= tone_bit_d;
         buzzer_q     <= buzzer_d;
         busy_q       <= busy_d;
         active_id_q  <= active_id_d;
`ifdef BUZZ_QUEUE_EN
         pend_valid_q <= pend_valid_d;
         pend_id_q    <= pend_id_d;
`endif
      end
   end

   assign buzzer    = buzzer_q;
   assign busy      = busy_q;
   assign active_id = active_id_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_buzzer_sequencer
//   Self-checking bench for buzzer_sequencer with small pattern parameters.
//   Directed scenarios compare against hand-derived constants; a randomized
//   run compares every cycle against an elapsed-time reference model.
// -----------------------------------------------------------------------------
module tb_buzzer_sequencer;

   localparam int KH  = 2;
   localparam int KL  = 10;
   localparam int OH  = 3;
   localparam int OL  = 14;
   localparam int EH  = 1;
   localparam int GLO = 4;
   localparam int GHI = 8;
   localparam int EL  = 12;

   logic       clk = 1'b0;
   logic       RSTn = 1'b1;
   logic       req_key = 1'b0;
   logic       req_ok = 1'b0;
   logic       req_err = 1'b0;
   logic       mute = 1'b0;
   logic       buzzer;
   logic       busy;
   logic [1:0] active_id;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model: owner id, cycles since its start, pending slot
   int         m_id = 0;
   int         m_d = 0;
   int         m_pv = 0;
   int         m_pid = 0;
   logic       e_buzz = 1'b0;
   logic       e_busy = 1'b0;
   logic [1:0] e_id = 2'd0;

   buzzer_sequencer #(
      .CNT_W(16), .KEY_HALF(KH), .KEY_LEN(KL), .OK_HALF(OH), .OK_LEN(OL),
      .ERR_HALF(EH), .ERR_GAP_LO(GLO), .ERR_GAP_HI(GHI), .ERR_LEN(EL)
   ) dut (
      .clk(clk), .RSTn(RSTn), .req_key(req_key), .req_ok(req_ok),
      .req_err(req_err), .mute(mute), .buzzer(buzzer), .busy(busy),
      .active_id(active_id)
   );

   always #5 clk = ~clk;

   function automatic int half_f(input int id);
      return (id == 1) ? KH : (id == 2) ? OH : EH;
   endfunction

   function automatic int len_f(input int id);
      return (id == 1) ? KL : (id == 2) ? OL : EL;
   endfunction

   task automatic model_step(input logic k, input logic o, input logic e,
                             input logic m, input logic r);
      int w;
      if (r) begin
         m_id = 0; m_d = 0; m_pv = 0; m_pid = 0;
      end else begin
         w = e ? 3 : (o ? 2 : (k ? 1 : 0));
         if (w != 0 && w >= m_id) begin
            m_id = w; m_d = 0;
         end else begin
`ifdef BUZZ_QUEUE_EN
            if (w != 0 && (m_pv == 0 || w >= m_pid)) begin
               m_pv = 1; m_pid = w;
            end
`endif
            if (m_id != 0) begin
               if (m_d == len_f(m_id) - 1) begin
                  if (m_pv != 0) begin
                     m_id = m_pid; m_d = 0; m_pv = 0;
                  end else begin
                     m_id = 0; m_d = 0;
                  end
               end else begin
                  m_d++;
               end
            end
         end
      end
      e_busy = (m_id != 0);
      e_id   = 2'(m_id);
      e_buzz = (m_id != 0) && (((m_d / half_f(m_id)) % 2) == 0) &&
               !(m_id == 3 && m_d >= GLO && m_d < GHI) && !m;
   endtask

   // drive one cycle of inputs, let the edge take them, sample 1 time unit later
   task automatic step(input logic k, input logic o, input logic e,
                       input logic m, input logic r);
      req_key = k; req_ok = o; req_err = e; mute = m; RSTn = r;
      @(posedge clk);
      model_step(k, o, e, m, r);
      #1;
   endtask

   task automatic test_reset;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({buzzer, busy, active_id} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 0000", {buzzer, busy, active_id});
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if ({buzzer, busy, active_id} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_beats_req: got %b want 0000", {buzzer, busy, active_id});
      end
   endtask

   task automatic test_key_click;
      logic [0:9] pat = 10'b1100110011;
      logic       eb;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 11; i++) begin
         step(i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
         eb = (i < 10) ? pat[i] : 1'b0;
         n_cmp++;
         if (buzzer !== eb || busy !== (i < 10) || active_id !== ((i < 10) ? 2'd1 : 2'd0)) begin
            n_fail++;
            $display("FAIL key_click cyc %0d: got buz=%b busy=%b id=%0d want buz=%b busy=%b id=%0d",
                     i + 1, buzzer, busy, active_id, eb, (i < 10), (i < 10) ? 1 : 0);
         end
      end
   endtask

   task automatic test_simultaneous;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (active_id !== 2'd3 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_winner: got id=%0d busy=%b want id=3 busy=1", active_id, busy);
      end
      for (int i = 1; i <= EL; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (busy !== 1'b0 || active_id !== 2'd0) begin
         n_fail++;
         $display("FAIL simul_dropped: got id=%0d busy=%b want id=0 busy=0", active_id, busy);
      end
   endtask

   task automatic test_err_gap;
      logic [0:11] gp = 12'b101000001010;
      logic        eb;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i <= EL; i++) begin
         step(1'b0, 1'b0, i == 0, 1'b0, 1'b0);
         eb = (i < EL) ? gp[i] : 1'b0;
         n_cmp++;
         if (buzzer !== eb || busy !== (i < EL)) begin
            n_fail++;
            $display("FAIL err_gap dur %0d: got buz=%b busy=%b want buz=%b busy=%b",
                     i, buzzer, busy, eb, (i < EL));
         end
      end
   endtask

   task automatic test_preempt_restart;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (active_id !== 2'd2 || buzzer !== 1'b1) begin
         n_fail++;
         $display("FAIL ok_preempts_key: got id=%0d buz=%b want id=2 buz=1", active_id, buzzer);
      end
      for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      // after the restart the pattern must run a full OL cycles again
      for (int d = 1; d < OL; d++) begin
         step(d == 5, 1'b0, 1'b0, 1'b0, 1'b0);
         n_cmp++;
         if (active_id !== 2'd2 || busy !== 1'b1 || buzzer !== (((d / OH) % 2) == 0)) begin
            n_fail++;
            $display("FAIL ok_restart dur %0d: got id=%0d busy=%b buz=%b want id=2 busy=1 buz=%b",
                     d, active_id, busy, buzzer, (((d / OH) % 2) == 0));
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
`ifdef BUZZ_QUEUE_EN
      if (active_id !== 2'd1 || busy !== 1'b1 || buzzer !== 1'b1) begin
         n_fail++;
         $display("FAIL queued_key: got id=%0d busy=%b buz=%b want id=1 busy=1 buz=1",
                  active_id, busy, buzzer);
      end
`else
      if (active_id !== 2'd0 || busy !== 1'b0 || buzzer !== 1'b0) begin
         n_fail++;
         $display("FAIL dropped_key: got id=%0d busy=%b buz=%b want id=0 busy=0 buz=0",
                  active_id, busy, buzzer);
      end
`endif
   endtask

   task automatic test_mute;
      logic [0:9] pat = 10'b1100110011;
      logic       mu;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i <= KL; i++) begin
         mu = (i >= 2 && i <= 6);
         step(i == 0, 1'b0, 1'b0, mu, 1'b0);
         n_cmp++;
         if (buzzer !== ((i < KL) ? (pat[i] & ~mu) : 1'b0) || busy !== (i < KL)) begin
            n_fail++;
            $display("FAIL mute dur %0d: got buz=%b busy=%b want buz=%b busy=%b",
                     i, buzzer, busy, (i < KL) ? (pat[i] & ~mu) : 1'b0, (i < KL));
         end
      end
   endtask

   task automatic test_reset_mid;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if ({buzzer, busy, active_id} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid_err: got %b want 0000", {buzzer, busy, active_id});
      end
   endtask

   task automatic test_restart_at_last;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < KL; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (busy !== 1'b1 || active_id !== 2'd1 || buzzer !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_at_last: got busy=%b id=%0d buz=%b want 1 1 1",
                  busy, active_id, buzzer);
      end
      for (int i = 1; i < KL; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_full_len: got busy=%b want 1", busy);
      end
   endtask

   task automatic test_random;
      logic k, o, e, m, r;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         k = ($urandom_range(0, 11) == 0);
         o = ($urandom_range(0, 29) == 0);
         e = ($urandom_range(0, 49) == 0);
         m = ($urandom_range(0, 7) == 0);
         r = ($urandom_range(0, 399) == 0);
         step(k, o, e, m, r);
         n_cmp++;
         if (buzzer !== e_buzz || busy !== e_busy || active_id !== e_id) begin
            n_fail++;
            $display("FAIL random cyc %0d: got buz=%b busy=%b id=%0d want buz=%b busy=%b id=%0d",
                     i, buzzer, busy, active_id, e_buzz, e_busy, e_id);
         end
      end
   endtask

   initial begin
      test_reset();
      test_key_click();
      test_simultaneous();
      test_err_gap();
      test_preempt_restart();
      test_mute();
      test_reset_mid();
      test_restart_at_last();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
